// File: rtl/rx_pkg.sv
// Shared types and defaults for the receive line-capture block.
package rx_pkg;

  // Line-capture FSM states. The 3-bit encoding leaves two unused codes,
  // and the FSM sends both of them back to RX_INIT.
  typedef enum logic [2:0] {
    RX_INIT     = 3'd0,
    RX_IDLE     = 3'd1,
    RX_STORE    = 3'd2,
    RX_ACK      = 3'd3,
    RX_WAIT_CLR = 3'd4,
    RX_HOLD     = 3'd5
  } rx_state_t;

  localparam logic [7:0]  DEFAULT_TERMINATOR = 8'h0A;
  localparam int unsigned DEFAULT_MAX_LEN    = 64;

endpackage

// File: rtl/line_ram.sv
// 256x8 simple dual-port line buffer: one write port, one registered read port.
module line_ram (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_we,
  input  logic [7:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic [7:0] i_rd_addr,
  output logic [7:0] o_rd_data
);

  logic [7:0] r_mem [256];
  logic [7:0] r_rd_data;

  // Write port: store one received byte at the current line position.
  // NOTE: the storage array has no reset; only the read register is cleared, so this still maps to block RAM.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: synchronous read every cycle, zeroed by reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rx_line_capture.sv
// Drains bytes from a UART receiver holding register into a line buffer and
// presents each completed line to a consumer through a random-access read port.
module rx_line_capture
  import rx_pkg::*;
#(
  parameter int unsigned MAX_LEN    = DEFAULT_MAX_LEN,
  parameter logic [7:0]  TERMINATOR = DEFAULT_TERMINATOR
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_full,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_clear,
  output logic       o_line_ready,
  output logic [7:0] o_line_length,
  input  logic [7:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  input  logic       i_line_taken,
  output logic       o_overrun
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  rx_state_t  r_state;
  logic [7:0] r_count;
  logic       r_done;
  logic       r_rx_clear;
  logic       r_line_ready;
  logic [7:0] r_line_length;
  logic       r_overrun;

  logic       w_we;
  logic [7:0] w_count_inc;

  // Count stays below MAX_LEN while in RX_STORE, so the increment never wraps.
  assign w_count_inc = r_count + 8'd1;
  assign w_we        = (r_state == RX_STORE) && (i_rx_data != TERMINATOR);

  line_ram u_line_ram (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_we      (w_we),
    .i_wr_addr (r_count),
    .i_wr_data (i_rx_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

  // Line-capture FSM with its counter and registered handshake/status outputs.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= RX_INIT;
      r_count       <= 8'd0;
      r_done        <= 1'b0;
      r_rx_clear    <= 1'b0;
      r_line_ready  <= 1'b0;
      r_line_length <= 8'd0;
      r_overrun     <= 1'b0;
    end else begin
      // RxClear is a single-cycle pulse unless a state below re-arms it.
      r_rx_clear <= 1'b0;
      case (r_state)
        RX_INIT: begin
          r_count      <= 8'd0;
          r_line_ready <= 1'b0;
          r_done       <= 1'b0;
          r_state      <= RX_IDLE;
        end

        RX_IDLE: begin
          if (i_rx_full) begin
            r_state <= RX_STORE;
          end
        end

        RX_STORE: begin
          if (i_rx_data == TERMINATOR) begin
            // Terminator is consumed but never written; an empty line is discarded.
            if (r_count == 8'd0) begin
              r_done <= 1'b0;
            end else begin
              r_line_length <= r_count;
              r_done        <= 1'b1;
            end
          end else begin
            r_count <= w_count_inc;
            if (w_count_inc == MAX_LEN_B) begin
              r_line_length <= MAX_LEN_B;
              r_done        <= 1'b1;
            end else begin
              r_done <= 1'b0;
            end
          end
          r_rx_clear <= 1'b1;
          r_state    <= RX_ACK;
        end

        RX_ACK: begin
          r_state <= RX_WAIT_CLR;
        end

        RX_WAIT_CLR: begin
          // Wait for the receiver to release the byte so it is never captured twice.
          if (!i_rx_full) begin
            if (r_done) begin
              r_line_ready <= 1'b1;
              r_state      <= RX_HOLD;
            end else begin
              r_state <= RX_IDLE;
            end
          end
        end

        RX_HOLD: begin
          // Release takes priority: a byte arriving with LineTaken is captured, not dropped.
          if (i_line_taken) begin
            r_count      <= 8'd0;
            r_line_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_done       <= 1'b0;
            r_state      <= RX_IDLE;
          end else if (i_rx_full) begin
            // Buffer is occupied: acknowledge and drop the byte, then come back here via Done.
            r_overrun  <= 1'b1;
            r_rx_clear <= 1'b1;
            r_state    <= RX_ACK;
          end
        end

        default: begin
          r_state <= RX_INIT;
        end
      endcase
    end
  end

  assign o_rx_clear    = r_rx_clear;
  assign o_line_ready  = r_line_ready;
  assign o_line_length = r_line_length;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_rx_line_capture.sv
// Scoreboard bench for rx_line_capture: a byte-stream model predicts completed
// lines; a monitor reads each presented line back and compares it.
module tb_rx_line_capture;

  localparam int         MAX_LEN = 4;
  localparam logic [7:0] TERM    = 8'h0A;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_rx_full;
  logic [7:0] i_rx_data;
  logic       o_rx_clear;
  logic       o_line_ready;
  logic [7:0] o_line_length;
  logic [7:0] i_rd_addr;
  logic [7:0] o_rd_data;
  logic       i_line_taken;
  logic       o_overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state: bytes of the line being assembled, and the
  // scoreboard of completed lines (lengths plus flattened contents).
  logic [7:0] cur_q[$];
  int         exp_len[$];
  logic [7:0] exp_bytes[$];
  bit         m_held     = 1'b0;
  bit         m_overrun  = 1'b0;
  int         m_held_len = 0;

  // Consumer control shared between stimulus and monitor.
  bit auto_take    = 1'b1;
  bit release_take = 1'b0;
  bit mon_waiting  = 1'b0;
  bit mon_busy     = 1'b0;

  int clear_cnt = 0;

  always #5 clk = ~clk;

  rx_line_capture #(
    .MAX_LEN    (MAX_LEN),
    .TERMINATOR (TERM)
  ) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_rx_full     (i_rx_full),
    .i_rx_data     (i_rx_data),
    .o_rx_clear    (o_rx_clear),
    .o_line_ready  (o_line_ready),
    .o_line_length (o_line_length),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .i_line_taken  (i_line_taken),
    .o_overrun     (o_overrun)
  );

  always @(posedge clk) begin
    if (o_rx_clear === 1'b1) clear_cnt <= clear_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: feed one accepted byte; reports whether it completes a line.
  task automatic model_byte(input logic [7:0] b, output bit done);
    done = 1'b0;
    if (b != TERM) cur_q.push_back(b);
    if ((b == TERM && cur_q.size() > 0) || cur_q.size() == MAX_LEN) begin
      exp_len.push_back(cur_q.size());
      m_held_len = cur_q.size();
      foreach (cur_q[i]) exp_bytes.push_back(cur_q[i]);
      cur_q.delete();
      m_held = 1'b1;
      done   = 1'b1;
    end
  endtask

  // Receiver-side handshake: present a byte, wait for RxClear, optionally
  // keep RxFull high for extra cycles, then release.
  task automatic send_byte(input logic [7:0] b, input int extra, input int exp_lat, input bit rel);
    int lat;
    int c0;
    @(negedge clk);
    c0        = clear_cnt;
    i_rx_data = b;
    i_rx_full = 1'b1;
    if (rel) release_take = 1'b1;
    lat = 0;
    while (o_rx_clear !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rxclear_latency", lat, exp_lat);
    repeat (extra) @(negedge clk);
    i_rx_full = 1'b0;
    repeat (2) @(negedge clk);
    check("rxclear_pulse_count", clear_cnt - c0, 1);
  endtask

  task automatic wait_consumed();
    int k = 0;
    while ((exp_len.size() != 0 || mon_busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("line_consumed_in_time", (k < 200), 1);
  endtask

  task automatic wait_mon_waiting();
    int k = 0;
    while (!mon_waiting && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("monitor_holding_line", mon_waiting, 1);
  endtask

  // Send one byte and predict its effect. rel=1 releases the held line in the
  // same cycle the byte appears.
  task automatic put(input logic [7:0] b, input int extra, input bit rel);
    bit done;
    bit drop;
    int lat_e;
    done = 1'b0;
    drop = m_held && !rel;
    if (rel) begin
      m_held    = 1'b0;
      m_overrun = 1'b0;
    end
    if (drop) m_overrun = 1'b1;
    else      model_byte(b, done);
    // Held line: HOLD reacts directly (1); release+byte: HOLD->IDLE->STORE->ACK (3).
    lat_e = drop ? 1 : (rel ? 3 : 2);
    send_byte(b, extra, lat_e, rel);
    check("line_ready_after_byte", o_line_ready, (drop || done));
    check("overrun_after_byte", o_overrun, m_overrun);
    if (drop) check("line_length_while_held", o_line_length, m_held_len);
    if (done && auto_take) wait_consumed();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_clear"},    o_rx_clear,    0);
    check({tag, "_line_ready"},  o_line_ready,  0);
    check({tag, "_line_length"}, o_line_length, 0);
    check({tag, "_overrun"},     o_overrun,     0);
    check({tag, "_rd_data"},     o_rd_data,     0);
  endtask

  // Monitor: whenever a line is presented, compare it with the scoreboard,
  // then release it (immediately, or when stimulus allows).
  initial begin : monitor
    int         len_e;
    logic [7:0] b_e;
    i_line_taken = 1'b0;
    i_rd_addr    = 8'h00;
    forever begin
      @(negedge clk);
      if (o_line_ready === 1'b1 && i_reset === 1'b0) begin
        mon_busy = 1'b1;
        if (exp_len.size() == 0) begin
          check("unexpected_line", o_line_ready, 0);
          len_e = 0;
        end else begin
          len_e = exp_len.pop_front();
          check("line_length", o_line_length, len_e);
        end
        for (int i = 0; i < len_e; i++) begin
          i_rd_addr = 8'(i);
          @(negedge clk);
          b_e = exp_bytes.pop_front();
          check("line_byte", o_rd_data, b_e);
        end
        check("overrun_before_take", o_overrun, m_overrun);
        if (!auto_take) begin
          mon_waiting = 1'b1;
          wait (release_take);
          release_take = 1'b0;
          mon_waiting  = 1'b0;
        end
        i_line_taken = 1'b1;
        m_held       = 1'b0;
        m_overrun    = 1'b0;
        @(negedge clk);
        i_line_taken = 1'b0;
        check("line_ready_after_take", o_line_ready, 0);
        check("overrun_after_take", o_overrun, 0);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] b;
    i_reset   = 1'b1;
    i_rx_full = 1'b0;
    i_rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    // "Hi\n" -> two-byte line 48 69
    put(8'h48, 0, 0);
    put(8'h69, 0, 0);
    put(TERM,  0, 0);

    // Lone terminator is an empty line; then "Z\n"
    put(TERM,  1, 0);
    put(8'h5A, 0, 0);
    put(TERM,  0, 0);

    // RxFull held 3 extra cycles: a single capture and a single RxClear
    put(8'h58, 3, 0);
    put(TERM,  0, 0);

    // "ABCDE" with MAX_LEN=4: line completes at 'D', 'E' is dropped
    auto_take = 1'b0;
    put(8'h41, 0, 0);
    put(8'h42, 0, 0);
    put(8'h43, 0, 0);
    put(8'h44, 0, 0);
    wait_mon_waiting();
    put(8'h45, 2, 0);
    @(negedge clk);
    release_take = 1'b1;
    wait_consumed();
    auto_take = 1'b1;

    // Byte arriving with LineTaken is captured as the start of the next line
    auto_take = 1'b0;
    put(8'h50, 0, 0);
    put(TERM,  0, 0);
    wait_mon_waiting();
    auto_take = 1'b1;
    put(8'h51, 0, 1);
    put(TERM,  0, 0);

    // Reset mid-line discards the partial line
    put(8'h41, 0, 0);
    put(8'h42, 0, 0);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midline_reset");
    i_reset = 1'b0;
    cur_q.delete();
    repeat (2) @(negedge clk);
    put(8'h43, 0, 0);
    put(TERM,  0, 0);

    // Randomized byte stream, terminators about one byte in four
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) b = TERM;
      else                           b = 8'($urandom_range(32, 126));
      put(b, int'($urandom_range(0, 3)), 0);
    end
    put(TERM, 0, 0);

    wait_consumed();
    check("scoreboard_drained", exp_len.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
